// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg
// Shared constants and helpers for the programmable clock divider.
//   CLK_HZ    : system clock frequency the default divisor is derived from
//   hz_to_div : divisor that produces a square wave of 'hz' at CLK_HZ
//               (one tick per half period, hence the factor of two)
//   DEF_DIV   : reset divisor, 10 Hz square wave at CLK_HZ
package clkdiv_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;

  function automatic int unsigned hz_to_div(input int unsigned hz);
    // A zero frequency has no meaningful divisor; return 0, which the
    // channels treat as the fastest setting rather than dividing by zero.
    if (hz == 0) begin
      return 0;
    end
    return CLK_HZ / (2 * hz);
  endfunction

  localparam int unsigned DEF_DIV = hz_to_div(10);

endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel
// One divider channel: counter, tick pulse and toggling square wave.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   en      : count enable; when low the channel freezes and tick drops
//   sync    : restart strobe, clears counter and outputs, beats en
//   div     : divisor from the owning register bank (0 behaves as 1)
//   tick    : registered one-cycle pulse every max(div,1) enabled cycles
//   wave    : registered square wave, toggles on every tick
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync,
  input  logic [CNT_W-1:0] div,
  output logic             tick,
  output logic             wave
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] last_cnt;
  logic             wrap;

  // last_cnt = max(div,1) - 1. Using >= instead of == lets the channel
  // recover at once when the divisor is lowered below the running count.
  always_comb begin
    last_cnt = (div == '0) ? '0 : div - CNT_W'(1);
    wrap     = (cnt_reg >= last_cnt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
      wave    <= 1'b0;
    end else if (sync) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
      wave    <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        cnt_reg <= '0;
        tick    <= 1'b1;
        wave    <= ~wave;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        tick    <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_divider_prog.sv
// clock_divider_prog
// N_CH independent programmable clock dividers with a shared write port.
//   i_clk      : system clock, rising edge
//   i_reset_n  : asynchronous active-low reset (deassertion synchronised
//                outside this block)
//   i_en       : per-channel count enable
//   i_sync     : one-cycle pulse restarting every channel phase-aligned
//   i_wr_en    : divisor write strobe
//   i_wr_ch    : channel written; indices >= N_CH are ignored
//   i_wr_div   : divisor value written
//   i_rd_ch    : channel whose divisor appears on o_rd_div
//   o_rd_div   : combinational divisor readback, 0 for indices >= N_CH
//   o_tick     : per-channel one-cycle pulse
//   o_clk      : per-channel 50% square wave, period 2*max(div,1)
module clock_divider_prog #(
  parameter int          N_CH    = 4,
  parameter int          CNT_W   = 32,
  parameter int unsigned DEF_DIV = clkdiv_pkg::DEF_DIV
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [N_CH-1:0]  i_en,
  input  logic             i_sync,
  input  logic             i_wr_en,
  input  logic [3:0]       i_wr_ch,
  input  logic [CNT_W-1:0] i_wr_div,
  input  logic [3:0]       i_rd_ch,
  output logic [CNT_W-1:0] o_rd_div,
  output logic [N_CH-1:0]  o_tick,
  output logic [N_CH-1:0]  o_clk
);

  logic [CNT_W-1:0] div_arr [N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] div_reg;

      // Write decode by exact index match: out-of-range indices match no
      // channel, so such writes fall through without side effects. The
      // counter is not touched; the new divisor takes over next cycle.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          div_reg <= CNT_W'(DEF_DIV);
        end else if (i_wr_en && (i_wr_ch == 4'(gi))) begin
          div_reg <= i_wr_div;
        end
      end

      assign div_arr[gi] = div_reg;

      clkdiv_channel #(
        .CNT_W(CNT_W)
      ) u_channel (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .en      (i_en[gi]),
        .sync    (i_sync),
        .div     (div_reg),
        .tick    (o_tick[gi]),
        .wave    (o_clk[gi])
      );
    end
  endgenerate

  // Readback mux; defaults to zero so unpopulated indices read as 0.
  always_comb begin
    o_rd_div = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (i_rd_ch == 4'(k)) begin
        o_rd_div = div_arr[k];
      end
    end
  end

endmodule
